// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM state type and one-hot index helper for the UART TX arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} uart_arb_state_t;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) idx = 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector; first requester at or after ptr, wrapping.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] upper;
    logic [N-1:0] src;

    // Requests at or above ptr take priority; otherwise wrap to the lowest set bit.
    always_comb begin
        upper = req & ~((N'(1) << ptr) - N'(1));
        src   = (|upper) ? upper : req;
        pick  = src & (~src + N'(1));
    end

    assign idx = IW'(onehot_to_idx(8'(pick)));
    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter; grant held per burst,
// released on last byte, burst limit or idle-gap timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_CLIENTS  = 4,
    parameter int MAX_BURST  = 16,
    parameter int GAP_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CLIENTS-1:0]   req_valid,
    input  logic [8*N_CLIENTS-1:0] req_data,
    input  logic [N_CLIENTS-1:0]   req_last,
    output logic [N_CLIENTS-1:0]   req_ready,
    output logic [N_CLIENTS-1:0]   grant,
    output logic                   uart_start,
    output logic [7:0]             uart_data,
    input  logic                   uart_ready,
    output logic                   arb_busy
);

    localparam int IW = $clog2(N_CLIENTS);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    uart_arb_state_t      state;
    uart_arb_state_t      state_d;
    logic [IW-1:0]        owner;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        pick_idx;
    logic [N_CLIENTS-1:0] pick;
    logic [BW-1:0]        burst;
    logic [GW-1:0]        gap;
    logic                 any;
    logic                 take;
    logic                 rel;
    logic                 gap_inc;
    logic                 xfer;
    logic                 owner_valid;
    logic                 last_q;

    rr_picker #(.N(N_CLIENTS)) u_picker (
        .req  (req_valid),
        .ptr  (ptr),
        .pick (pick),
        .idx  (pick_idx),
        .any  (any)
    );

    assign owner_valid = |(grant & req_valid);
    assign xfer        = (state == SEND) && uart_ready && owner_valid;
    assign req_ready   = (state == SEND && uart_ready) ? (grant & req_valid) : '0;
    assign arb_busy    = |grant;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        take    = 1'b0;
        rel     = 1'b0;
        gap_inc = 1'b0;
        case (state)
            IDLE: begin
                take    = any;
                state_d = any ? SEND : IDLE;
            end
            SEND: begin
                state_d = xfer ? WAIT_ACK : SEND;
                rel     = !owner_valid && (gap == GW'(GAP_CYCLES - 1));
                gap_inc = !owner_valid && !rel;
            end
            WAIT_ACK:  state_d = uart_ready ? WAIT_ACK : WAIT_DONE;
            WAIT_DONE: begin
                rel     = uart_ready && (last_q || burst == BW'(MAX_BURST));
                state_d = uart_ready ? SEND : WAIT_DONE;
            end
            default:   state_d = IDLE;
        endcase
        if (rel) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant      <= '0;
            owner      <= '0;
            ptr        <= '0;
            burst      <= '0;
            gap        <= '0;
            last_q     <= 1'b0;
            uart_start <= 1'b0;
            uart_data  <= 8'h00;
        end else begin
            uart_start <= xfer;
            if (take) begin
                grant <= pick;
                owner <= pick_idx;
                burst <= '0;
                gap   <= '0;
            end
            if (xfer) begin
                uart_data <= req_data[{owner, 3'b000} +: 8];
                last_q    <= |(grant & req_last);
                burst     <= burst + BW'(1);
                gap       <= '0;
            end
            if (gap_inc) gap <= gap + GW'(1);
            if (rel) begin
                grant <= '0;
                ptr   <= (owner == IW'(N_CLIENTS - 1)) ? '0 : owner + IW'(1);
            end
        end
    end

endmodule
